nios_pio_out_pulse: RTL and testbench



---
 rtl/nios_pio_out_pulse.sv | 150 +++++++++++++++
 tb/tb_nios_pio_out_pulse.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/nios_pio_out_pulse.sv
// Avalon-MM output PIO with atomic set/clear/toggle writes and an optional one-shot
// pulse engine (define PIO_OUT_PULSE_EN to build addresses 4-6 and the pulse logic).
module nios_pio_out_pulse #(
    parameter int unsigned           DATA_WIDTH        = 2,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE       = '0,
    parameter int unsigned           CNT_WIDTH         = 24,
    parameter int unsigned           PULSE_LEN_DEFAULT = 1000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic [DATA_WIDTH-1:0] out_port
);

    localparam logic [2:0] AddrData     = 3'd0;
    localparam logic [2:0] AddrSet      = 3'd1;
    localparam logic [2:0] AddrClear    = 3'd2;
    localparam logic [2:0] AddrToggle   = 3'd3;
`ifdef PIO_OUT_PULSE_EN
    localparam logic [2:0] AddrPulse    = 3'd4;
    localparam logic [2:0] AddrPulseLen = 3'd5;
    localparam logic [2:0] AddrStatus   = 3'd6;
`endif

    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wd_data;
    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] data_d;

    // Bits above DATA_WIDTH/CNT_WIDTH are deliberately dropped.
    logic unused_writedata;
    assign unused_writedata = ^writedata;

    assign wr_en   = chipselect & ~write_n;
    assign wd_data = writedata[DATA_WIDTH-1:0];

    always_comb begin
        data_d = data_q;
        if (wr_en) begin
            case (address)
                AddrData:   data_d = wd_data;
                AddrSet:    data_d = data_q | wd_data;
                AddrClear:  data_d = data_q & ~wd_data;
                AddrToggle: data_d = data_q ^ wd_data;
                default:    data_d = data_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= RESET_VALUE;
        end else begin
            data_q <= data_d;
        end
    end

`ifdef PIO_OUT_PULSE_EN
    logic [CNT_WIDTH-1:0]  wd_cnt;
    logic [CNT_WIDTH-1:0]  pulse_len_q;
    logic [CNT_WIDTH-1:0]  pulse_len_d;
    logic [CNT_WIDTH-1:0]  count_q;
    logic [CNT_WIDTH-1:0]  count_d;
    logic [DATA_WIDTH-1:0] mask_q;
    logic [DATA_WIDTH-1:0] mask_d;
    logic                  busy;
    logic [32:0]           status_w;
    logic                  unused_status;

    assign wd_cnt = writedata[CNT_WIDTH-1:0];
    assign busy   = (count_q != '0);

    always_comb begin
        pulse_len_d = pulse_len_q;
        mask_d      = mask_q;
        count_d     = count_q;
        if (busy) begin
            count_d = count_q - CNT_WIDTH'(1);
            if (count_q == CNT_WIDTH'(1)) begin
                mask_d = '0;
            end
        end
        // A PULSE write overrides the running countdown (retrigger or cancel).
        if (wr_en) begin
            case (address)
                AddrPulse: begin
                    mask_d = wd_data;
                    if ((wd_data == '0) || (pulse_len_q == '0)) begin
                        count_d = '0;
                    end else begin
                        count_d = pulse_len_q;
                    end
                end
                AddrPulseLen: pulse_len_d = wd_cnt;
                default:      pulse_len_d = pulse_len_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pulse_len_q <= CNT_WIDTH'(PULSE_LEN_DEFAULT);
            count_q     <= '0;
            mask_q      <= '0;
        end else begin
            pulse_len_q <= pulse_len_d;
            count_q     <= count_d;
            mask_q      <= mask_d;
        end
    end

    // Built 33 bits wide so a 32-bit counter still maps onto bits [CNT_WIDTH:1].
    always_comb begin
        status_w               = '0;
        status_w[CNT_WIDTH:1]  = count_q;
        status_w[0]            = busy;
    end
    assign unused_status = status_w[32];

    assign out_port = data_q ^ (busy ? mask_q : '0);

    always_comb begin
        readdata = '0;
        case (address)
            AddrData:     readdata[DATA_WIDTH-1:0] = data_q;
            AddrPulse:    readdata[DATA_WIDTH-1:0] = mask_q;
            AddrPulseLen: readdata[CNT_WIDTH-1:0]  = pulse_len_q;
            AddrStatus:   readdata                 = status_w[31:0];
            default:      readdata                 = '0;
        endcase
    end
`else
    logic [CNT_WIDTH-1:0] unused_cfg;
    assign unused_cfg = CNT_WIDTH'(PULSE_LEN_DEFAULT);

    assign out_port = data_q;

    always_comb begin
        readdata = '0;
        if (address == AddrData) begin
            readdata[DATA_WIDTH-1:0] = data_q;
        end
    end
`endif

endmodule

// File: tb/tb_nios_pio_out_pulse.sv
// Directed bench for nios_pio_out_pulse; follows PIO_OUT_PULSE_EN to pick the expected map.
module tb_nios_pio_out_pulse;

    localparam logic [1:0] ResetVal = 2'b10;
`ifdef PIO_OUT_PULSE_EN
    localparam logic [31:0] LenDefExp = 32'd1000;
`else
    localparam logic [31:0] LenDefExp = 32'd0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [1:0]  out_port;
    logic [31:0] rd;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    nios_pio_out_pulse #(
        .DATA_WIDTH       (2),
        .RESET_VALUE      (ResetVal),
        .CNT_WIDTH        (24),
        .PULSE_LEN_DEFAULT(1000)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .out_port  (out_port)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        #1;
        d = readdata;
    endtask

`ifdef PIO_OUT_PULSE_EN
    // Entered just after the load edge; walks the countdown then checks the restore.
    task automatic run_pulse(input string tag, input logic [1:0] on_val,
                             input logic [1:0] off_val, input int len);
        logic [31:0] st;
        for (int i = len; i >= 1; i--) begin
            check({tag, "_out"}, {30'd0, out_port}, {30'd0, on_val});
            bus_read(3'd6, st);
            check({tag, "_status"}, st, (i << 1) | 1);
            step();
        end
        check({tag, "_end_out"}, {30'd0, out_port}, {30'd0, off_val});
        bus_read(3'd6, st);
        check({tag, "_end_status"}, st, 32'd0);
    endtask
`endif

    initial begin
        reset      = 1'b1;
        address    = 3'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        step();
        step();
        check("rst_out", {30'd0, out_port}, {30'd0, ResetVal});
        bus_read(3'd6, rd); check("rst_status", rd, 32'd0);
        bus_read(3'd5, rd); check("rst_len", rd, LenDefExp);
        bus_read(3'd4, rd); check("rst_mask", rd, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        step();

        bus_write(3'd0, 32'h1); check("data_out",   {30'd0, out_port}, 32'h1);
        bus_write(3'd1, 32'h2); check("set_out",    {30'd0, out_port}, 32'h3);
        bus_write(3'd2, 32'h1); check("clear_out",  {30'd0, out_port}, 32'h2);
        bus_write(3'd3, 32'h3); check("toggle_out", {30'd0, out_port}, 32'h1);
        bus_read(3'd0, rd); check("rd_data",   rd, 32'h1);
        bus_read(3'd1, rd); check("rd_set",    rd, 32'h0);
        bus_read(3'd2, rd); check("rd_clear",  rd, 32'h0);
        bus_read(3'd3, rd); check("rd_toggle", rd, 32'h0);
        bus_read(3'd7, rd); check("rd_addr7",  rd, 32'h0);
        bus_write(3'd7, 32'h3); check("wr_addr7_out", {30'd0, out_port}, 32'h1);
        bus_write(3'd0, 32'hFFFF_FFFC); check("data_upper_ignored", {30'd0, out_port}, 32'h0);
        bus_write(3'd0, 32'h1);

`ifdef PIO_OUT_PULSE_EN
        bus_write(3'd5, 32'd5);
        bus_read(3'd5, rd); check("len_rd", rd, 32'd5);
        bus_write(3'd0, 32'h0); check("data0_out", {30'd0, out_port}, 32'h0);

        bus_write(3'd4, 32'h1);
        bus_read(3'd4, rd); check("mask_rd", rd, 32'h1);
        run_pulse("p1", 2'b01, 2'b00, 5);

        // Retrigger two cycles into a pulse on bit0 with a bit1 mask.
        bus_write(3'd4, 32'h1); check("rt_a0", {30'd0, out_port}, 32'h1);
        step();                 check("rt_a1", {30'd0, out_port}, 32'h1);
        bus_write(3'd4, 32'h2);
        run_pulse("rt", 2'b10, 2'b00, 5);

        bus_write(3'd4, 32'h1); check("cancel_on", {30'd0, out_port}, 32'h1);
        bus_write(3'd4, 32'h0); check("cancel_out", {30'd0, out_port}, 32'h0);
        bus_read(3'd6, rd);     check("cancel_status", rd, 32'h0);

        // Data update mid-pulse: pulse keeps inverting bit0 over the new value.
        bus_write(3'd4, 32'h1);
        bus_write(3'd0, 32'h2);
        run_pulse("dw", 2'b11, 2'b10, 4);

        // PULSE_LEN change while busy only applies to the next trigger.
        bus_write(3'd4, 32'h1);
        bus_write(3'd5, 32'd2);
        run_pulse("lb", 2'b11, 2'b10, 4);
        bus_write(3'd4, 32'h1);
        run_pulse("l2", 2'b11, 2'b10, 2);

        bus_write(3'd5, 32'd0);
        bus_write(3'd4, 32'h1); check("len0_out", {30'd0, out_port}, 32'h2);
        bus_read(3'd6, rd);     check("len0_status", rd, 32'h0);

        bus_write(3'd5, 32'd5);
        bus_write(3'd0, 32'h3);
        bus_write(3'd4, 32'h1); check("rm_pulse_out", {30'd0, out_port}, 32'h2);
        @(negedge clk);
        reset = 1'b1;
        step();
        check("rm_out", {30'd0, out_port}, {30'd0, ResetVal});
        bus_read(3'd6, rd); check("rm_status", rd, 32'h0);
        bus_read(3'd5, rd); check("rm_len", rd, 32'd1000);
        bus_read(3'd4, rd); check("rm_mask", rd, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            check("rm_after_out", {30'd0, out_port}, {30'd0, ResetVal});
        end
        bus_read(3'd6, rd); check("rm_after_status", rd, 32'h0);
`else
        bus_write(3'd4, 32'h3); check("nopulse_out", {30'd0, out_port}, 32'h1);
        step();                 check("nopulse_out2", {30'd0, out_port}, 32'h1);
        bus_write(3'd5, 32'd7);
        bus_write(3'd6, 32'h1); check("nopulse_out3", {30'd0, out_port}, 32'h1);
        bus_read(3'd4, rd); check("nopulse_rd4", rd, 32'h0);
        bus_read(3'd5, rd); check("nopulse_rd5", rd, 32'h0);
        bus_read(3'd6, rd); check("nopulse_rd6", rd, 32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
